ber_sweep_ctrl: RTL

BER_SWEEP_CTRL -- requirements
Module: ber_sweep_ctrl

---
 rtl/ber_sweep_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ber_sweep_ctrl.sv
// BER sweep sequencer: steps the quantizer SNR index and runs the LDPC decoder
// frame by frame, counting bit and frame errors against an all-zero codeword.
module ber_sweep_ctrl #(
  parameter int DIM       = 2304,
  parameter int CHUNK     = 96,
  parameter int SNR_START = 0,
  parameter int SNR_STOP  = 15,
  parameter int FRAMES    = 1000,
  parameter int MAX_FERR  = 100,
  parameter int TIMEOUT   = 4096,
  parameter int FRAC_W    = -1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                fill_done,
  input  logic                term,
  input  logic [DIM-1:0]      res,
  output logic                ldpc_en,
  output logic                buff_clr,
  output logic [3:0]          snr_idx,
  output logic signed [4:0]   frac_w,
  output logic                busy,
  output logic                done,
  output logic [11:0]         frame_errs,
  output logic                res_valid,
  output logic [15:0]         res_frames,
  output logic [15:0]         res_ferr,
  output logic [31:0]         res_berr
);

  localparam int NCHUNK = DIM / CHUNK;
  localparam int CI_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_COUNT  = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_REPORT = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [11:0]      DIM_ERRS   = 12'(DIM);
  localparam logic [3:0]       SNR_FIRST  = 4'(SNR_START);
  localparam logic [3:0]       SNR_LAST   = 4'(SNR_STOP);
  localparam logic [15:0]      FRAMES_LIM = 16'(FRAMES);
  localparam logic [15:0]      FERR_LIM   = 16'(MAX_FERR);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [CI_W-1:0]  CHUNK_LAST = CI_W'(NCHUNK - 1);

  logic [2:0]       state_q, state_d;
  logic [3:0]       snr_idx_q, snr_idx_d;
  logic [15:0]      frames_q, frames_d;
  logic [15:0]      ferr_q, ferr_d;
  logic [31:0]      berr_q, berr_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [DIM-1:0]   res_q, res_d;
  logic [CI_W-1:0]  chunk_q, chunk_d;
  logic [11:0]      fbits_q, fbits_d;
  logic [11:0]      frame_errs_q, frame_errs_d;
  logic [15:0]      res_frames_q, res_frames_d;
  logic [15:0]      res_ferr_q, res_ferr_d;
  logic [31:0]      res_berr_q, res_berr_d;

  logic [CHUNK-1:0] chunk_bits;
  logic [11:0]      fbits_sum;
  logic [15:0]      frames_inc;
  logic [15:0]      ferr_inc;
  logic [32:0]      berr_sum;
  logic [31:0]      berr_sat;

  function automatic logic [11:0] popcount(input logic [CHUNK-1:0] v);
    logic [11:0] n;
    n = '0;
    for (int i = 0; i < CHUNK; i++) begin
      n = n + 12'(v[i]);
    end
    return n;
  endfunction

  // Per-frame accumulation and saturating point totals, computed ahead of UPDATE.
  always_comb begin
    chunk_bits = res_q[int'(chunk_q) * CHUNK +: CHUNK];
    fbits_sum  = fbits_q + popcount(chunk_bits);
    frames_inc = frames_q + 16'd1;
    ferr_inc   = ferr_q + ((frame_errs_q != 12'd0) ? 16'd1 : 16'd0);
    berr_sum   = {1'b0, berr_q} + 33'(frame_errs_q);
    berr_sat   = berr_sum[32] ? '1 : berr_sum[31:0];
  end

  always_comb begin
    state_d      = state_q;
    snr_idx_d    = snr_idx_q;
    frames_d     = frames_q;
    ferr_d       = ferr_q;
    berr_d       = berr_q;
    tmo_d        = tmo_q;
    res_d        = res_q;
    chunk_d      = chunk_q;
    fbits_d      = fbits_q;
    frame_errs_d = frame_errs_q;
    res_frames_d = res_frames_q;
    res_ferr_d   = res_ferr_q;
    res_berr_d   = res_berr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_FILL;
          snr_idx_d = SNR_FIRST;
          frames_d  = '0;
          ferr_d    = '0;
          berr_d    = '0;
        end
      end
      S_FILL: begin
        if (fill_done) begin
          state_d = S_DECODE;
          tmo_d   = '0;
        end
      end
      S_DECODE: begin
        if (term) begin
          state_d = S_COUNT;
          res_d   = res;
          chunk_d = '0;
          fbits_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          // A decoder that never converges is scored as every bit wrong.
          state_d      = S_UPDATE;
          frame_errs_d = DIM_ERRS;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_COUNT: begin
        if (chunk_q == CHUNK_LAST) begin
          state_d      = S_UPDATE;
          frame_errs_d = fbits_sum;
        end else begin
          fbits_d = fbits_sum;
          chunk_d = chunk_q + 1'b1;
        end
      end
      S_UPDATE: begin
        frames_d = frames_inc;
        ferr_d   = ferr_inc;
        berr_d   = berr_sat;
        if ((frames_inc == FRAMES_LIM) || (ferr_inc == FERR_LIM)) begin
          state_d      = S_REPORT;
          res_frames_d = frames_inc;
          res_ferr_d   = ferr_inc;
          res_berr_d   = berr_sat;
        end else begin
          state_d = S_FILL;
        end
      end
      S_REPORT: begin
        if (snr_idx_q == SNR_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d   = S_FILL;
          snr_idx_d = snr_idx_q + 4'd1;
          frames_d  = '0;
          ferr_d    = '0;
          berr_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      snr_idx_q    <= SNR_FIRST;
      frames_q     <= '0;
      ferr_q       <= '0;
      berr_q       <= '0;
      tmo_q        <= '0;
      res_q        <= '0;
      chunk_q      <= '0;
      fbits_q      <= '0;
      frame_errs_q <= '0;
      res_frames_q <= '0;
      res_ferr_q   <= '0;
      res_berr_q   <= '0;
    end else begin
      state_q      <= state_d;
      snr_idx_q    <= snr_idx_d;
      frames_q     <= frames_d;
      ferr_q       <= ferr_d;
      berr_q       <= berr_d;
      tmo_q        <= tmo_d;
      res_q        <= res_d;
      chunk_q      <= chunk_d;
      fbits_q      <= fbits_d;
      frame_errs_q <= frame_errs_d;
      res_frames_q <= res_frames_d;
      res_ferr_q   <= res_ferr_d;
      res_berr_q   <= res_berr_d;
    end
  end

  // buff_clr fires on the start cycle itself, so it is combinational on start.
  assign buff_clr   = !rst && ((((state_q == S_IDLE) || (state_q == S_DONE)) && start)
                               || (state_q == S_UPDATE));
  assign ldpc_en    = (state_q == S_DECODE);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign res_valid  = (state_q == S_REPORT);
  assign snr_idx    = snr_idx_q;
  assign frac_w     = 5'(FRAC_W);
  assign frame_errs = frame_errs_q;
  assign res_frames = res_frames_q;
  assign res_ferr   = res_ferr_q;
  assign res_berr   = res_berr_q;

endmodule
